// File: rtl/bus_s_ahb_sram.sv
// AHB-Lite SRAM responder: word array with byte/half lanes; optional ERROR on misaligned
// (AHB_SRAM_ERRRESP_EN). Latency: WAIT_CYC wait cycles per data phase, zero-wait when 0.
// Backpressure: HREADYOUT held low during WAIT/ERR1; accepts a new address in DATA/ERR2.
module bus_s_ahb_sram #(
  parameter int ADDR_WIDTH = 12,
  parameter int WAIT_CYC   = 0,
  parameter int WAIT_W     = 4
) (
  input  logic        CLK,
  input  logic        RES_SYS_N,
  input  logic        S_HSEL,
  input  logic [1:0]  S_HTRANS,
  input  logic        S_HWRITE,
  input  logic        S_HMASTLOCK,
  input  logic [2:0]  S_HSIZE,
  input  logic [2:0]  S_HBURST,
  input  logic [3:0]  S_HPROT,
  input  logic [31:0] S_HADDR,
  input  logic [31:0] S_HWDATA,
  input  logic        S_HREADY,
  output logic        S_HREADYOUT,
  output logic [31:0] S_HRDATA,
  output logic        S_HRESP
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       mem_q [DEPTH];

  logic       accept;
  logic       start;
  logic       misalign;
  logic [3:0] be_new;
  logic       mem_we;
  logic       unused_ok;

  assign accept    = S_HSEL & S_HTRANS[1] & S_HREADY;
  assign unused_ok = &{1'b0, S_HMASTLOCK, S_HBURST, S_HPROT, S_HADDR[31:ADDR_WIDTH], S_HTRANS[0]};

  // Little-endian lanes; with the error response disabled, low address bits
  // that would make the access misaligned simply drop out of the lane select.
  always_comb begin
    be_new = 4'b1111;
    case (S_HSIZE)
      3'b000:  be_new = 4'b0001 << S_HADDR[1:0];
      3'b001:  be_new = S_HADDR[1] ? 4'b1100 : 4'b0011;
      default: be_new = 4'b1111;
    endcase
  end

`ifdef AHB_SRAM_ERRRESP_EN
  always_comb begin
    misalign = 1'b0;
    case (S_HSIZE)
      3'b000:  misalign = 1'b0;
      3'b001:  misalign = S_HADDR[0];
      default: misalign = (S_HADDR[1:0] != 2'b00);
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    be_d    = be_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) start = 1'b1;
        else        state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DATA;
        else             cnt_d = cnt_q - WAIT_W'(1);
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      write_d = S_HWRITE;
      idx_d   = S_HADDR[ADDR_WIDTH-1:2];
      be_d    = be_new;
      if (misalign) begin
        state_d = ST_ERR1;
      end else if (WAIT_CYC > 0) begin
        state_d = ST_WAIT;
        cnt_d   = WAIT_INIT;
      end else begin
        state_d = ST_DATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RES_SYS_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
    end
  end

  // Array is deliberately not reset; a reset in the write data phase blocks the commit.
  assign mem_we = (state_q == ST_DATA) & write_q & RES_SYS_N;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= S_HWDATA[8*b +: 8];
      end
    end
  end

  assign S_HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign S_HRDATA    = ((state_q == ST_DATA) && !write_q) ? mem_q[idx_q] : '0;

`ifdef AHB_SRAM_ERRRESP_EN
  assign S_HRESP = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
  assign S_HRESP = 1'b0;
`endif

endmodule

// File: tb/tb_bus_s_ahb_sram.sv
// Directed bench for bus_s_ahb_sram: one zero-wait instance and one WAIT_CYC=3 instance
// sharing the address/data bus, each with its own HSEL and HREADY loop-back.
module tb_bus_s_ahb_sram;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        sel0, sel3, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;
  logic        rdy0, rdy3, resp0, resp3;
  logic [31:0] rdata0, rdata3;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  bus_s_ahb_sram #(.ADDR_WIDTH(12), .WAIT_CYC(0), .WAIT_W(4)) u_dut0 (
    .CLK(CLK), .RES_SYS_N(rst_n), .S_HSEL(sel0), .S_HTRANS(htrans), .S_HWRITE(hwrite),
    .S_HMASTLOCK(1'b0), .S_HSIZE(hsize), .S_HBURST(3'b000), .S_HPROT(4'b0011),
    .S_HADDR(haddr), .S_HWDATA(hwdata), .S_HREADY(rdy0),
    .S_HREADYOUT(rdy0), .S_HRDATA(rdata0), .S_HRESP(resp0)
  );

  bus_s_ahb_sram #(.ADDR_WIDTH(12), .WAIT_CYC(3), .WAIT_W(4)) u_dut3 (
    .CLK(CLK), .RES_SYS_N(rst_n), .S_HSEL(sel3), .S_HTRANS(htrans), .S_HWRITE(hwrite),
    .S_HMASTLOCK(1'b0), .S_HSIZE(hsize), .S_HBURST(3'b000), .S_HPROT(4'b0011),
    .S_HADDR(haddr), .S_HWDATA(hwdata), .S_HREADY(rdy3),
    .S_HREADYOUT(rdy3), .S_HRDATA(rdata3), .S_HRESP(resp3)
  );

  task automatic go_idle();
    sel0 = 1'b0; sel3 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  // One complete single transfer: address phase, then data phase until HREADYOUT.
  task automatic xfer(input bit d3, input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output int nlo,
                      output logic resp_lo, output logic resp_hi, output bit to);
    sel0 = !d3; sel3 = d3; htrans = 2'b10; hwrite = wr; hsize = sz; haddr = addr;
    @(posedge CLK); #1;
    go_idle();
    hwdata = wd;
    nlo = 0; resp_lo = 1'b0; resp_hi = 1'b0; rd = '0; to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if ((d3 ? rdy3 : rdy0) === 1'b1) begin
        rd = d3 ? rdata3 : rdata0;
        resp_hi = d3 ? resp3 : resp0;
        to = 1'b0;
        break;
      end
      nlo++;
      resp_lo = resp_lo | (d3 ? resp3 : resp0);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go_idle(); hsize = 3'b010; haddr = '0; hwdata = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if ({rdy0, resp0, rdata0} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_dut0: got rdy=%b resp=%b rdata=%h want 1 0 00000000", rdy0, resp0, rdata0);
    end
    total++;
    if ({rdy3, resp3, rdata3} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_dut3: got rdy=%b resp=%b rdata=%h want 1 0 00000000", rdy3, resp3, rdata3);
    end
    @(posedge CLK); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; int n; logic rl, rh; bit to;
    xfer(1'b0, 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, rd, n, rl, rh, to);
    total++;
    if (to || n != 0 || rh !== 1'b0) begin
      bad++; $display("FAIL word_write: got timeout=%0d waits=%0d resp=%b want 0 0 0", to, n, rh);
    end
    xfer(1'b0, 1'b0, 3'b010, 32'h010, 32'h0, rd, n, rl, rh, to);
    total++;
    if (to || n != 0 || rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL word_read: got timeout=%0d waits=%0d data=%h want 0 0 deadbeef", to, n, rd);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; int n; logic rl, rh; bit to;
    logic [2:0]  sz  [4] = '{3'b010, 3'b000, 3'b001, 3'b000};
    logic [31:0] ad  [4] = '{32'h010, 32'h013, 32'h012, 32'h010};
    logic [31:0] wd  [4] = '{32'h11223344, 32'hA5A5A5A5, 32'hBEEFBEEF, 32'h77777777};
    logic [31:0] exp [4] = '{32'h11223344, 32'hA5223344, 32'hBEEF3344, 32'hBEEF3377};
    for (int k = 0; k < 4; k++) begin
      xfer(1'b0, 1'b1, sz[k], ad[k], wd[k], rd, n, rl, rh, to);
      xfer(1'b0, 1'b0, 3'b010, 32'h010, 32'h0, rd, n, rl, rh, to);
      total++;
      if (to || rd !== exp[k]) begin
        bad++; $display("FAIL lanes_%0d: got timeout=%0d data=%h want %h", k, to, rd, exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel0 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h020;
    @(posedge CLK); #1;
    hwdata = 32'h12345678;
    hwrite = 1'b0; haddr = 32'h020;
    @(negedge CLK);
    total++;
    if ({rdy0, rdata0} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL b2b_write_phase: got rdy=%b rdata=%h want 1 00000000", rdy0, rdata0);
    end
    @(posedge CLK); #1;
    go_idle();
    @(negedge CLK);
    total++;
    if ({rdy0, rdata0} !== {1'b1, 32'h12345678}) begin
      bad++; $display("FAIL b2b_read_phase: got rdy=%b rdata=%h want 1 12345678", rdy0, rdata0);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; int n; logic rl, rh; bit to;
    xfer(1'b0, 1'b1, 3'b010, 32'h022, 32'h55667788, rd, n, rl, rh, to);
`ifdef AHB_SRAM_ERRRESP_EN
    total++;
    if (to || n != 1 || rl !== 1'b1 || rh !== 1'b1) begin
      bad++; $display("FAIL misalign_resp: got timeout=%0d waits=%0d resp_lo=%b resp_hi=%b want 0 1 1 1", to, n, rl, rh);
    end
    xfer(1'b0, 1'b0, 3'b010, 32'h020, 32'h0, rd, n, rl, rh, to);
    total++;
    if (to || rd !== 32'h12345678) begin
      bad++; $display("FAIL misalign_mem: got timeout=%0d data=%h want 12345678", to, rd);
    end
`else
    total++;
    if (to || n != 0 || rh !== 1'b0) begin
      bad++; $display("FAIL misalign_resp: got timeout=%0d waits=%0d resp=%b want 0 0 0", to, n, rh);
    end
    xfer(1'b0, 1'b0, 3'b010, 32'h020, 32'h0, rd, n, rl, rh, to);
    total++;
    if (to || rd !== 32'h55667788) begin
      bad++; $display("FAIL misalign_mem: got timeout=%0d data=%h want 55667788", to, rd);
    end
`endif
  endtask

  task automatic test_idle();
    logic [31:0] rd; int n; logic rl, rh; bit to;
    sel0 = 1'b1; htrans = 2'b01; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h010;
    @(posedge CLK); #1;
    go_idle(); hwdata = 32'hFFFFFFFF;
    @(negedge CLK);
    total++;
    if ({rdy0, resp0, rdata0} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL idle_busy: got rdy=%b resp=%b rdata=%h want 1 0 00000000", rdy0, resp0, rdata0);
    end
    @(posedge CLK); #1;
    sel0 = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h010;
    @(posedge CLK); #1;
    go_idle();
    @(negedge CLK);
    total++;
    if ({rdy0, resp0, rdata0} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL idle_unsel: got rdy=%b resp=%b rdata=%h want 1 0 00000000", rdy0, resp0, rdata0);
    end
    @(posedge CLK); #1;
    xfer(1'b0, 1'b0, 3'b010, 32'h010, 32'h0, rd, n, rl, rh, to);
    total++;
    if (to || rd !== 32'hBEEF3377) begin
      bad++; $display("FAIL idle_mem: got timeout=%0d data=%h want beef3377", to, rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; int n; logic rl, rh; bit to; bit got;
    xfer(1'b1, 1'b1, 3'b010, 32'h040, 32'hCAFEF00D, rd, n, rl, rh, to);
    total++;
    if (to || n != 3) begin
      bad++; $display("FAIL wait_write: got timeout=%0d waits=%0d want 0 3", to, n);
    end
    // Keep a second NONSEQ pending throughout the first data phase.
    sel3 = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010; haddr = 32'h040;
    @(posedge CLK); #1;
    for (int beat = 0; beat < 2; beat++) begin
      n = 0; got = 1'b0; rd = '0;
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        if (rdy3 === 1'b1) begin rd = rdata3; got = 1'b1; break; end
        n++;
      end
      @(posedge CLK); #1;
      go_idle();
      total++;
      if (!got || n != 3 || rd !== 32'hCAFEF00D) begin
        bad++; $display("FAIL wait_read_%0d: got ready_seen=%0d waits=%0d data=%h want 1 3 cafef00d", beat, got, n, rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int n; logic rl, rh; bit to;
    xfer(1'b1, 1'b1, 3'b010, 32'h060, 32'h0BADF00D, rd, n, rl, rh, to);
    sel3 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h060;
    @(posedge CLK); #1;
    go_idle(); hwdata = 32'hFFFFFFFF;
    @(negedge CLK);
    total++;
    if (rdy3 !== 1'b0) begin
      bad++; $display("FAIL rstmid_wait: got rdy=%b want 0", rdy3);
    end
    @(posedge CLK); #1;
    rst_n = 1'b0;
    @(posedge CLK); #1;
    rst_n = 1'b1;
    @(negedge CLK);
    total++;
    if ({rdy3, resp3, rdata3} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL rstmid_state: got rdy=%b resp=%b rdata=%h want 1 0 00000000", rdy3, resp3, rdata3);
    end
    repeat (4) @(posedge CLK);
    #1;
    xfer(1'b1, 1'b0, 3'b010, 32'h060, 32'h0, rd, n, rl, rh, to);
    total++;
    if (to || rd !== 32'h0BADF00D) begin
      bad++; $display("FAIL rstmid_mem: got timeout=%0d data=%h want 0badf00d", to, rd);
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_lanes();
    test_back_to_back();
    test_misaligned();
    test_idle();
    test_wait_states();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
